bwn_layer_scheduler: RTL

BWN_LAYER_SCHEDULER -- requirements
Module: bwn_layer_scheduler

---
 rtl/bwn_layer_scheduler.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/bwn_layer_scheduler.sv
// Layer sequencer for a 4-layer binary-weight network: loads a frame, then walks every
// neuron of every layer. Optional cycle counter enabled by define BWN_SCHED_CYCLE_CNT_EN.
module bwn_layer_scheduler #(
  parameter int unsigned CLASS_NUM1  = 120,
  parameter int unsigned CLASS_NUM2  = 80,
  parameter int unsigned CLASS_NUM3  = 40,
  parameter int unsigned CLASS_NUM4  = 3,
  parameter int unsigned INPUT_SIZE1 = 1274,
  parameter int unsigned INPUT_SIZE2 = 120,
  parameter int unsigned INPUT_SIZE3 = 80,
  parameter int unsigned INPUT_SIZE4 = 40,
  parameter int unsigned D_WL        = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   busy,
  output logic                   buf_wr_en,
  output logic                   buf_wr_bank,
  output logic [10:0]            buf_wr_addr,
  output logic                   act_rd_bank,
  output logic [10:0]            act_rd_addr,
  output logic [17:0]            w_rd_addr,
  output logic                   mac_clr,
  output logic                   mac_en,
  output logic [1:0]             layer_sel,
  input  logic signed [D_WL-1:0] acc_in,
  output logic                   out_valid,
  output logic [1:0]             led,
  output logic [31:0]            frame_cycles
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] CLR   = 3'd2;
  localparam logic [2:0] ACC   = 3'd3;
  localparam logic [2:0] DRAIN = 3'd4;
  localparam logic [2:0] WB    = 3'd5;
  localparam logic [2:0] DONE  = 3'd6;

  logic [2:0]             state_q, state_d;
  logic [10:0]            load_cnt_q, load_cnt_d;
  logic [10:0]            k_q, k_d;
  logic [10:0]            n_q, n_d;
  logic [1:0]             layer_q, layer_d;
  logic                   bank_q, bank_d;
  logic [17:0]            w_row_q, w_row_d;
  logic                   mac_en_q;
  logic signed [D_WL-1:0] max_q, max_d;
  logic [1:0]             best_q, best_d;
  logic [1:0]             led_q, led_d;
  logic [10:0]            in_size, class_num;
  logic                   last_k, last_n, take_max, start_compute;

  always_comb begin
    unique case (layer_q)
      2'd0: begin in_size = 11'(INPUT_SIZE1); class_num = 11'(CLASS_NUM1); end
      2'd1: begin in_size = 11'(INPUT_SIZE2); class_num = 11'(CLASS_NUM2); end
      2'd2: begin in_size = 11'(INPUT_SIZE3); class_num = 11'(CLASS_NUM3); end
      default: begin in_size = 11'(INPUT_SIZE4); class_num = 11'(CLASS_NUM4); end
    endcase
  end

  assign last_k   = (k_q == in_size - 11'd1);
  assign last_n   = (n_q == class_num - 11'd1);
  // Neuron 0 seeds the maximum; strict compare keeps the lowest index on ties.
  assign take_max = (n_q == 11'd0) || (acc_in > max_q);

  always_comb begin
    state_d       = state_q;
    load_cnt_d    = load_cnt_q;
    k_d           = k_q;
    n_d           = n_q;
    layer_d       = layer_q;
    bank_d        = bank_q;
    w_row_d       = w_row_q;
    max_d         = max_q;
    best_d        = best_q;
    led_d         = led_q;
    start_compute = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          load_cnt_d = 11'd1;
          if (INPUT_SIZE1 == 1) start_compute = 1'b1;
          else                  state_d       = LOAD;
        end
      end
      LOAD: begin
        if (in_valid) begin
          load_cnt_d = load_cnt_q + 11'd1;
          if (load_cnt_q == 11'(INPUT_SIZE1 - 1)) start_compute = 1'b1;
        end
      end
      CLR: begin
        k_d     = 11'd0;
        state_d = ACC;
      end
      ACC: begin
        k_d = k_q + 11'd1;
        if (last_k) state_d = DRAIN;
      end
      DRAIN: state_d = WB;
      WB: begin
        // Weights are packed row after row, so the next row base is also the next layer base.
        w_row_d = w_row_q + 18'(in_size);
        if (layer_q == 2'd3 && take_max) begin
          max_d  = acc_in;
          best_d = n_q[1:0];
        end
        if (!last_n) begin
          n_d     = n_q + 11'd1;
          state_d = CLR;
        end else if (layer_q == 2'd3) begin
          led_d   = take_max ? n_q[1:0] : best_q;
          state_d = DONE;
        end else begin
          layer_d = layer_q + 2'd1;
          bank_d  = ~bank_q;
          n_d     = 11'd0;
          state_d = CLR;
        end
      end
      DONE: begin
        layer_d = 2'd0;
        bank_d  = 1'b0;
        n_d     = 11'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (start_compute) begin
      load_cnt_d = 11'd0;
      layer_d    = 2'd0;
      n_d        = 11'd0;
      bank_d     = 1'b0;
      w_row_d    = 18'd0;
      state_d    = CLR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      load_cnt_q <= '0;
      k_q        <= '0;
      n_q        <= '0;
      layer_q    <= '0;
      bank_q     <= 1'b0;
      w_row_q    <= '0;
      mac_en_q   <= 1'b0;
      max_q      <= '0;
      best_q     <= '0;
      led_q      <= '0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      k_q        <= k_d;
      n_q        <= n_d;
      layer_q    <= layer_d;
      bank_q     <= bank_d;
      w_row_q    <= w_row_d;
      mac_en_q   <= (state_q == ACC);
      max_q      <= max_d;
      best_q     <= best_d;
      led_q      <= led_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign buf_wr_en   = rst_n && ((((state_q == IDLE) || (state_q == LOAD)) && in_valid) ||
                                 (state_q == WB));
  assign buf_wr_bank = (state_q == WB) ? ~bank_q : 1'b0;
  assign buf_wr_addr = (state_q == WB) ? n_q :
                       ((state_q == IDLE) || (state_q == LOAD)) ? load_cnt_q : 11'd0;
  assign act_rd_bank = bank_q;
  assign act_rd_addr = (state_q == ACC) ? k_q : 11'd0;
  assign w_rd_addr   = (state_q == ACC) ? (w_row_q + 18'(k_q)) : 18'd0;
  assign mac_clr     = (state_q == CLR);
  assign mac_en      = mac_en_q;
  assign layer_sel   = layer_q;
  assign out_valid   = (state_q == DONE);
  assign led         = led_q;

`ifdef BWN_SCHED_CYCLE_CNT_EN
  logic [31:0] cyc_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                            cyc_q <= '0;
    else if (start_compute)                                cyc_q <= '0;
    else if (state_q inside {CLR, ACC, DRAIN, WB, DONE})   cyc_q <= cyc_q + 32'd1;
  end
  assign frame_cycles = cyc_q;
`else
  assign frame_cycles = 32'd0;
`endif

endmodule
